draw_map: RTL
=============

DRAW_MAP -- requirements
Module: draw_map

Interface
REQ-001 Parameter MAP_W, default 16, map width in cells (1..16).
REQ-002 Parameter MAP_H, default 16, map height in cells (1..16).
REQ-003 Parameter ORIGIN_X, default 0, screen x of cell (0,0) top-left pixel.
REQ-004 Parameter ORIGIN_Y, default 0, screen y of cell (0,0) top-left pixel.
REQ-005 Parameter SKIP_BLACK, default 0, when 1 cells with colour 3'b000 are not drawn.
REQ-006 clock  input  1  system clock, all state on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  request one full map redraw; sampled only in IDLE.
REQ-009 done  output  1  one-cycle pulse when the redraw completes.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 map_addr  output  8  map memory address = row*MAP_W + col.
REQ-012 map_data  input  3  cell colour; synchronous memory, valid the cycle after map_addr is presented.
REQ-013 sq_start  output  1  one-cycle request to the 4x4 square drawer.
REQ-014 sq_done  input  1  one-cycle completion pulse from the square drawer.
REQ-015 sq_x  output  9  top-left x of square = ORIGIN_X + 4*col.
REQ-016 sq_y  output  8  top-left y of square = ORIGIN_Y + 4*row.
REQ-017 sq_colour  output  3  colour of square = fetched map_data.

Function
REQ-018 States SHALL be IDLE, FETCH, MEM_WAIT, ISSUE, SQ_WAIT, ADVANCE, DONE.
REQ-019 IDLE -> FETCH on start=1, clearing col and row to 0; otherwise stay.
REQ-020 FETCH SHALL drive map_addr for (row,col); next state MEM_WAIT.
REQ-021 MEM_WAIT SHALL register map_data into sq_colour and compute sq_x/sq_y; next ISSUE, or ADVANCE if SKIP_BLACK=1 and map_data=0.
REQ-022 ISSUE SHALL assert sq_start for exactly one cycle; next SQ_WAIT.
REQ-023 SQ_WAIT SHALL hold until sq_done=1, then go to ADVANCE.
REQ-024 sq_x, sq_y, sq_colour SHALL remain stable from the ISSUE cycle through the cycle sq_done is seen.
REQ-025 ADVANCE: col==MAP_W-1 and row==MAP_H-1 -> DONE; col==MAP_W-1 -> col=0,row+1, FETCH; else col+1, FETCH.
REQ-026 DONE SHALL assert done for one cycle; next IDLE.
REQ-027 Cell order SHALL be row-major, row 0 first, col ascending.
REQ-028 Address and coordinate arithmetic SHALL be unsigned, truncated to output width; ORIGIN_X+4*MAP_W <= 320 and ORIGIN_Y+4*MAP_H <= 240 are integration constraints, not checked.
REQ-029 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-030 sq_done received outside SQ_WAIT SHALL be ignored.
REQ-031 Latency with square drawer taking D cycles from sq_start to sq_done: 1 (FETCH) + 1 (MEM_WAIT) + 1 (ISSUE) + D (SQ_WAIT) + 1 (ADVANCE) cycles per drawn cell.
REQ-032 Skipped cells SHALL take 3 cycles (FETCH, MEM_WAIT, ADVANCE) and produce no sq_start.

Reset
REQ-033 On reset state SHALL be IDLE, col=row=0, done=0, busy=0, sq_start=0, map_addr=0, sq_x=0, sq_y=0, sq_colour=0.
REQ-034 Reset mid-redraw SHALL abort immediately with no further sq_start or done pulse.

Structure
REQ-035 State encodings and cell pitch constant (4) SHALL live in shared package draw_pkg, also used by the square drawer.
REQ-036 Design SHALL be split into an FSM and a datapath sub-module draw_map_datapath (counters, address, coordinate registers).

Verification
REQ-037 MAP_W=2,MAP_H=2, map {1,2,3,4}, sq_done 5 cycles after sq_start -> four sq_start pulses at (0,0,1),(4,0,2),(0,4,3),(4,4,4), then one done pulse.
REQ-038 Same map, SKIP_BLACK=1, cell 1 = 0 -> three sq_start pulses, (4,0) absent, done after third sq_done.
REQ-039 ORIGIN_X=100, ORIGIN_Y=50, 16x16 -> last square at (160,110), 256 sq_start pulses, map_addr reaches 255.
REQ-040 start pulsed during SQ_WAIT and sq_done pulsed during FETCH -> no extra redraw, no early advance.
REQ-041 reset asserted in SQ_WAIT of cell 3 -> next cycle busy=0, sq_start=0, no done; new start redraws from cell 0.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the map renderer and the 4x4 square drawer:
// controller state encodings, cell pitch and output widths.
package draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_SQ_WAIT  = 3'd4,
        ST_ADVANCE  = 3'd5,
        ST_DONE     = 3'd6
    } draw_state_t;

    // One map cell is drawn as a CELL_PITCH x CELL_PITCH pixel square.
    localparam int unsigned CELL_PITCH = 32'd4;

    localparam int unsigned IDX_W    = 32'd4;
    localparam int unsigned ADDR_W   = 32'd8;
    localparam int unsigned X_W      = 32'd9;
    localparam int unsigned Y_W      = 32'd8;
    localparam int unsigned COLOUR_W = 32'd3;

    // Screen coordinate of a cell edge; callers truncate to their port width.
    function automatic int unsigned cell_pos(input int unsigned origin,
                                             input logic [IDX_W-1:0] idx);
        return origin + (CELL_PITCH * {28'd0, idx});
    endfunction

endpackage

// File: rtl/draw_map_datapath.sv
// Datapath for the map renderer: column/row counters, linear map address
// and the registered square coordinates and colour handed to the drawer.
module draw_map_datapath
    import draw_pkg::*;
#(
    parameter int unsigned MAP_W    = 32'd16,
    parameter int unsigned MAP_H    = 32'd16,
    parameter int unsigned ORIGIN_X = 32'd0,
    parameter int unsigned ORIGIN_Y = 32'd0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clr,
    input  logic                load,
    input  logic                adv,
    input  logic [COLOUR_W-1:0] map_data,
    output logic [ADDR_W-1:0]   map_addr,
    output logic [X_W-1:0]      sq_x,
    output logic [Y_W-1:0]      sq_y,
    output logic [COLOUR_W-1:0] sq_colour,
    output logic                last_cell
);

    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(MAP_W - 32'd1);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(MAP_H - 32'd1);

    logic [IDX_W-1:0]    col_r;
    logic [IDX_W-1:0]    row_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [X_W-1:0]      sq_x_r;
    logic [Y_W-1:0]      sq_y_r;
    logic [COLOUR_W-1:0] sq_colour_r;
    logic                col_last_s;
    logic                last_cell_s;

    assign col_last_s  = (col_r == COL_LAST);
    assign last_cell_s = col_last_s && (row_r == ROW_LAST);

    // Walk cells row-major; the address tracks row*MAP_W+col as a running
    // count because consecutive cells are always one address apart.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_r  <= {IDX_W{1'b0}};
            row_r  <= {IDX_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (clr) begin
            col_r  <= {IDX_W{1'b0}};
            row_r  <= {IDX_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (adv && !last_cell_s) begin
            addr_r <= addr_r + 8'd1;
            if (col_last_s) begin
                col_r <= {IDX_W{1'b0}};
                row_r <= row_r + 4'd1;
            end else begin
                col_r <= col_r + 4'd1;
                row_r <= row_r;
            end
        end else begin
            col_r  <= col_r;
            row_r  <= row_r;
            addr_r <= addr_r;
        end
    end

    // Capture the fetched colour and the square position once per cell;
    // they then hold steady while the drawer works on the square.
    always_ff @(posedge clock) begin
        if (reset) begin
            sq_x_r      <= {X_W{1'b0}};
            sq_y_r      <= {Y_W{1'b0}};
            sq_colour_r <= {COLOUR_W{1'b0}};
        end else if (load) begin
            sq_x_r      <= X_W'(cell_pos(ORIGIN_X, col_r));
            sq_y_r      <= Y_W'(cell_pos(ORIGIN_Y, row_r));
            sq_colour_r <= map_data;
        end else begin
            sq_x_r      <= sq_x_r;
            sq_y_r      <= sq_y_r;
            sq_colour_r <= sq_colour_r;
        end
    end

    assign map_addr  = addr_r;
    assign sq_x      = sq_x_r;
    assign sq_y      = sq_y_r;
    assign sq_colour = sq_colour_r;
    assign last_cell = last_cell_s;

endmodule

// File: rtl/draw_map.sv
// Map renderer: on start, fetches every cell of a MAP_W x MAP_H colour map
// from synchronous memory and asks the square drawer to paint a 4x4 square
// for each, optionally skipping black cells.
module draw_map
    import draw_pkg::*;
#(
    parameter int unsigned MAP_W      = 32'd16,
    parameter int unsigned MAP_H      = 32'd16,
    parameter int unsigned ORIGIN_X   = 32'd0,
    parameter int unsigned ORIGIN_Y   = 32'd0,
    parameter bit          SKIP_BLACK = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                done,
    output logic                busy,
    output logic [ADDR_W-1:0]   map_addr,
    input  logic [COLOUR_W-1:0] map_data,
    output logic                sq_start,
    input  logic                sq_done,
    output logic [X_W-1:0]      sq_x,
    output logic [Y_W-1:0]      sq_y,
    output logic [COLOUR_W-1:0] sq_colour
);

    draw_state_t state_r;
    logic        busy_r;
    logic        done_r;
    logic        sq_start_r;
    logic        clr_s;
    logic        load_s;
    logic        adv_s;
    logic        skip_s;
    logic        last_cell_s;

    // Datapath strobes decoded from the current state.
    assign clr_s  = (state_r == ST_IDLE) && start;
    assign load_s = (state_r == ST_MEM_WAIT);
    assign adv_s  = (state_r == ST_ADVANCE);
    assign skip_s = SKIP_BLACK && (map_data == 3'b000);

    // Controller: one pass over the map, with outputs registered alongside
    // the state so sq_start and done are clean single-cycle pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sq_start_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            sq_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_FETCH;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (skip_s) begin
                        state_r <= ST_ADVANCE;
                    end else begin
                        state_r    <= ST_ISSUE;
                        sq_start_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_SQ_WAIT;
                end
                ST_SQ_WAIT: begin
                    if (sq_done) begin
                        state_r <= ST_ADVANCE;
                    end else begin
                        state_r <= ST_SQ_WAIT;
                    end
                end
                ST_ADVANCE: begin
                    if (last_cell_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    draw_map_datapath #(
        .MAP_W    (MAP_W),
        .MAP_H    (MAP_H),
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y)
    ) u_datapath (
        .clock     (clock),
        .reset     (reset),
        .clr       (clr_s),
        .load      (load_s),
        .adv       (adv_s),
        .map_data  (map_data),
        .map_addr  (map_addr),
        .sq_x      (sq_x),
        .sq_y      (sq_y),
        .sq_colour (sq_colour),
        .last_cell (last_cell_s)
    );

    assign busy     = busy_r;
    assign done     = done_r;
    assign sq_start = sq_start_r;

endmodule
